// File: rtl/pcie_rst_pkg.sv
// Shared definitions for the PCIe HIP reset sequencer: FSM states and the
// bit positions of the exit-source vector {sw, ltssm, dlup, hotrst, l2}.
package pcie_rst_pkg;

    typedef enum logic [1:0] {
        IDLE_RST = 2'd0,
        COUNT    = 2'd1,
        STAGGER  = 2'd2,
        RUN      = 2'd3
    } rst_state_e;

    localparam int EXIT_W     = 5;
    localparam int EXB_L2     = 0;
    localparam int EXB_HOTRST = 1;
    localparam int EXB_DLUP   = 2;
    localparam int EXB_LTSSM  = 3;
    localparam int EXB_SW     = 4;

endpackage

// File: rtl/pcie_rst_exit_det.sv
// Exit-event detector: registers the HIP exit inputs, masks them into a source
// vector, and produces the registered exit strobe plus the sticky cause.
module pcie_rst_exit_det
    import pcie_rst_pkg::*;
#(
    parameter logic [4:0]        LTSSM_DETECT = 5'h10,
    parameter logic [EXIT_W-1:0] EXIT_MASK    = 5'b11111
) (
    input  logic              pld_clk,
    input  logic              any_rstn_rr,
    input  logic              dlup_exit,
    input  logic              hotrst_exit,
    input  logic              l2_exit,
    input  logic [4:0]        ltssm,
    input  logic              sw_rst_req,
    output logic              o_exits_r,
    output logic [EXIT_W-1:0] o_rst_cause
);

    logic              r_dlup;
    logic              r_hotrst;
    logic              r_l2;
    logic              r_sw;
    logic [4:0]        r_ltssm;
    logic [EXIT_W-1:0] w_src;

    // Exit inputs are active-low pulses; ltssm matches a single detect code.
    always_comb begin
        w_src             = '0;
        w_src[EXB_L2]     = ~r_l2;
        w_src[EXB_HOTRST] = ~r_hotrst;
        w_src[EXB_DLUP]   = ~r_dlup;
        w_src[EXB_LTSSM]  = (r_ltssm == LTSSM_DETECT);
        w_src[EXB_SW]     = r_sw;
        w_src             = w_src & EXIT_MASK;
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_dlup      <= 1'b1;
            r_hotrst    <= 1'b1;
            r_l2        <= 1'b1;
            r_sw        <= 1'b0;
            r_ltssm     <= '0;
            o_exits_r   <= 1'b0;
            o_rst_cause <= '0;
        end else begin
            r_dlup    <= dlup_exit;
            r_hotrst  <= hotrst_exit;
            r_l2      <= l2_exit;
            r_sw      <= sw_rst_req;
            r_ltssm   <= ltssm;
            o_exits_r <= |w_src;
            if (|w_src)
                o_rst_cause <= w_src;
        end
    end

endmodule

// File: rtl/pcie_hip_rst_seq.sv
// PCIe HIP reset sequencer: holds srst/crst for a counted interval after reset
// or any exit event, then releases the application resets one by one.
module pcie_hip_rst_seq
    import pcie_rst_pkg::*;
#(
    parameter int         CNT_W           = 11,
    parameter int         RELEASE_CNT     = 1024,
    parameter int         EXIT_PRELOAD    = 'h3F0,
    parameter int         SIM_RELEASE_CNT = 32,
    parameter int         N_APP           = 2,
    parameter int         APP_STAGGER     = 16,
    parameter logic [4:0] LTSSM_DETECT    = 5'h10,
    parameter logic [4:0] EXIT_MASK       = 5'b11111
) (
    input  logic             pld_clk,
    input  logic             any_rstn_rr,
    input  logic             dlup_exit,
    input  logic             hotrst_exit,
    input  logic             l2_exit,
    input  logic [4:0]       ltssm,
    input  logic             test_sim,
    input  logic             sw_rst_req,
    output logic             srst,
    output logic             crst,
    output logic [N_APP-1:0] app_rstn,
    output logic [4:0]       rst_cause,
    output logic [7:0]       exit_cnt,
    output logic             busy
);

    if (RELEASE_CNT >= (1 << CNT_W) || EXIT_PRELOAD >= (1 << CNT_W) ||
        EXIT_PRELOAD > RELEASE_CNT || N_APP < 1 || N_APP > 8) begin : g_param_err
        $error("pcie_hip_rst_seq: illegal counter/app parameters");
    end

    localparam int                 STG_W     = $clog2((N_APP - 1) * APP_STAGGER + 2);
    localparam logic [CNT_W:0]     REL_C     = (CNT_W + 1)'(RELEASE_CNT);
    localparam logic [CNT_W:0]     SIM_C     = (CNT_W + 1)'(SIM_RELEASE_CNT);
    localparam logic [CNT_W-1:0]   PRELOAD_C = CNT_W'(EXIT_PRELOAD);

    rst_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W:0]   w_cnt_inc;
    logic [STG_W-1:0] r_stg, w_stg_nxt, w_stg_inc;
    logic             r_rst0, w_rst0_nxt;
    logic [N_APP-1:0] r_app0, w_app0_nxt;
    logic             w_rel;
    logic             w_exits_r;
    logic [7:0]       r_exit_cnt;

    pcie_rst_exit_det #(
        .LTSSM_DETECT (LTSSM_DETECT),
        .EXIT_MASK    (EXIT_MASK)
    ) u_exit_det (
        .pld_clk     (pld_clk),
        .any_rstn_rr (any_rstn_rr),
        .dlup_exit   (dlup_exit),
        .hotrst_exit (hotrst_exit),
        .l2_exit     (l2_exit),
        .ltssm       (ltssm),
        .sw_rst_req  (sw_rst_req),
        .o_exits_r   (w_exits_r),
        .o_rst_cause (rst_cause)
    );

    // Release is decided on the incremented value so it coincides with the
    // counter reaching the threshold.
    always_comb begin
        w_cnt_inc   = {1'b0, r_cnt} + (CNT_W + 1)'(1);
        w_stg_inc   = r_stg + STG_W'(1);
        w_rel       = test_sim ? (w_cnt_inc >= SIM_C) : (w_cnt_inc == REL_C);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stg_nxt   = r_stg;
        w_rst0_nxt  = r_rst0;
        w_app0_nxt  = r_app0;
        if (w_exits_r) begin
            w_state_nxt = COUNT;
            w_cnt_nxt   = PRELOAD_C;
            w_stg_nxt   = '0;
            w_rst0_nxt  = 1'b1;
            w_app0_nxt  = '0;
        end else begin
            case (r_state)
                IDLE_RST: w_state_nxt = COUNT;
                COUNT: begin
                    if (~&r_cnt)
                        w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                    if (w_rel) begin
                        w_rst0_nxt    = 1'b0;
                        w_app0_nxt[0] = 1'b1;
                        w_stg_nxt     = '0;
                        w_state_nxt   = STAGGER;
                    end
                end
                STAGGER: begin
                    w_stg_nxt = w_stg_inc;
                    for (int i = 1; i < N_APP; i++)
                        if (w_stg_inc == STG_W'(i * APP_STAGGER))
                            w_app0_nxt[i] = 1'b1;
                    if (&r_app0)
                        w_state_nxt = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_state    <= IDLE_RST;
            r_cnt      <= '0;
            r_stg      <= '0;
            r_rst0     <= 1'b1;
            r_app0     <= '0;
            r_exit_cnt <= '0;
            srst       <= 1'b1;
            crst       <= 1'b1;
            app_rstn   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stg    <= w_stg_nxt;
            r_rst0   <= w_rst0_nxt;
            r_app0   <= w_app0_nxt;
            srst     <= r_rst0;
            crst     <= r_rst0;
            app_rstn <= r_app0;
            if (w_exits_r && ~&r_exit_cnt)
                r_exit_cnt <= r_exit_cnt + 8'd1;
        end
    end

    assign exit_cnt = r_exit_cnt;
    assign busy     = srst | crst | ~&app_rstn;

endmodule

// File: tb/tb_pcie_hip_rst_seq.sv
// Randomized scoreboard bench for pcie_hip_rst_seq: expected srst/app_rstn
// transitions are derived from exit/reset timing and checked by a monitor.
module tb_pcie_hip_rst_seq;

    localparam int REL = 1024;
    localparam int PRE = 'h3F0;
    localparam int STG = 16;
    localparam int SIMREL = 32;
    localparam int TOL = 1;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_APP1 = 2;
    localparam logic [4:0] MASK_M = 5'b01111;

    typedef struct {
        int         kind;
        int         cyc;
        logic [4:0] cause;
        int         cnt;
    } ev_t;

    logic       pld_clk = 1'b0;
    logic       any_rstn_rr = 1'b1;
    logic       dlup_exit = 1'b1, hotrst_exit = 1'b1, l2_exit = 1'b1;
    logic [4:0] ltssm = 5'd0;
    logic       test_sim = 1'b0;
    logic       sw_rst_req = 1'b0;

    logic       srst, crst, busy;
    logic [1:0] app_rstn;
    logic [4:0] rst_cause;
    logic [7:0] exit_cnt;
    logic       m_srst, m_crst, m_busy;
    logic [1:0] m_app_rstn;
    logic [4:0] m_rst_cause;
    logic [7:0] m_exit_cnt;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         m_cnt = 0;
    int         m2_cnt = 0;
    logic [4:0] m2_cause = 5'd0;
    logic [4:0] idle_ltssm = 5'd0;
    bit         sb_on = 1'b0;
    logic       p_srst = 1'b1;
    logic       p_app1 = 1'b0;
    ev_t        sbq[$];

    pcie_hip_rst_seq dut (
        .pld_clk(pld_clk), .any_rstn_rr(any_rstn_rr), .dlup_exit(dlup_exit),
        .hotrst_exit(hotrst_exit), .l2_exit(l2_exit), .ltssm(ltssm),
        .test_sim(test_sim), .sw_rst_req(sw_rst_req), .srst(srst), .crst(crst),
        .app_rstn(app_rstn), .rst_cause(rst_cause), .exit_cnt(exit_cnt), .busy(busy)
    );

    pcie_hip_rst_seq #(.EXIT_MASK(MASK_M)) dut_m (
        .pld_clk(pld_clk), .any_rstn_rr(any_rstn_rr), .dlup_exit(dlup_exit),
        .hotrst_exit(hotrst_exit), .l2_exit(l2_exit), .ltssm(ltssm),
        .test_sim(test_sim), .sw_rst_req(sw_rst_req), .srst(m_srst), .crst(m_crst),
        .app_rstn(m_app_rstn), .rst_cause(m_rst_cause), .exit_cnt(m_exit_cnt), .busy(m_busy)
    );

    always #5 pld_clk = ~pld_clk;
    always @(posedge pld_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [4:0] cause, input int cnt);
        ev_t e;
        e.kind = kind; e.cyc = c; e.cause = cause; e.cnt = cnt;
        sbq.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        n_chk++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = sbq.pop_front();
        n_chk++;
        if (e.kind != kind || cyc < e.cyc - TOL || cyc > e.cyc + TOL) begin
            n_fail++;
            $display("FAIL event_timing: kind %0d at cycle %0d, expected kind %0d at cycle %0d +-%0d",
                     kind, cyc, e.kind, e.cyc, TOL);
        end
        if (kind != K_RISE) begin
            chk("rst_cause", rst_cause, e.cause);
            chk("exit_cnt", exit_cnt, e.cnt);
        end
        chk("crst", crst, (kind == K_RISE) ? 1 : 0);
        chk("app_rstn0", app_rstn[0], (kind == K_RISE) ? 0 : 1);
        chk("busy", busy, (kind == K_APP1) ? 0 : 1);
    endtask

    always @(negedge pld_clk) begin
        if (sb_on) begin
            if (srst !== p_srst)
                take(p_srst ? K_FALL : K_RISE);
            if (app_rstn[1] && !p_app1)
                take(K_APP1);
        end
        p_srst = srst;
        p_app1 = app_rstn[1];
    end

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge pld_clk);
            k++;
        end
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d events pending after %0d cycles, expected 0", sbq.size(), budget);
            sbq.delete();
        end
    endtask

    task automatic set_src(input logic [4:0] s);
        l2_exit     = ~s[0];
        hotrst_exit = ~s[1];
        dlup_exit   = ~s[2];
        ltssm       = s[3] ? 5'h10 : idle_ltssm;
        sw_rst_req  = s[4];
    endtask

    task automatic pulse(input logic [4:0] s, input int n);
        set_src(s);
        repeat (n) @(negedge pld_clk);
        set_src(5'd0);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_exit(input logic [4:0] s, input int n);
        m_cnt = sat(m_cnt + n);
        if ((s & MASK_M) != 5'd0) begin
            m2_cause = s & MASK_M;
            m2_cnt   = sat(m2_cnt + n);
        end
    endtask

    task automatic reset_release(input int fall_delay);
        int rel;
        repeat (3) @(negedge pld_clk);
        rel = cyc;
        any_rstn_rr = 1'b1;
        m_cnt = 0; m2_cnt = 0; m2_cause = 5'd0;
        push(K_FALL, rel + fall_delay, 5'd0, 0);
        push(K_APP1, rel + fall_delay + STG, 5'd0, 0);
        sb_on = 1'b1;
    endtask

    initial begin
        int first, last, na, nb, mode;
        logic [4:0] sa, sb;

        #1 any_rstn_rr = 1'b0;
        repeat (2) @(negedge pld_clk);
        chk("rst_srst", srst, 1);
        chk("rst_crst", crst, 1);
        chk("rst_app", app_rstn, 0);
        chk("rst_cause0", rst_cause, 0);
        chk("rst_cnt0", exit_cnt, 0);
        chk("rst_busy", busy, 1);

        // Power-on sequence: 1 IDLE edge + RELEASE counts + output register.
        reset_release(2 + REL);
        drain(1200);

        // Single-cycle dlup exit from RUN.
        @(negedge pld_clk);
        first = cyc + 1; last = first;
        model_exit(5'b00100, 1);
        push(K_RISE, first + 3, 5'd0, 0);
        push(K_FALL, last + 2 + (REL - PRE), 5'b00100, 1);
        push(K_APP1, last + 2 + (REL - PRE) + STG, 5'b00100, 1);
        pulse(5'b00100, 1);
        drain(100);

        for (int it = 0; it < 10; it++) begin
            do idle_ltssm = 5'($urandom_range(0, 31)); while (idle_ltssm == 5'h10);
            ltssm = idle_ltssm;
            repeat ($urandom_range(1, 20)) @(negedge pld_clk);
            sa = 5'($urandom_range(1, 31)); na = $urandom_range(1, 3);
            mode = $urandom_range(0, 2);
            first = cyc + 1; last = first + na - 1;
            model_exit(sa, na);
            push(K_RISE, first + 3, 5'd0, 0);
            if (mode == 1) begin
                // Second exit while still counting: re-preload, no new rise.
                pulse(sa, na);
                repeat ($urandom_range(4, 11)) @(negedge pld_clk);
                sb = 5'($urandom_range(1, 31)); nb = $urandom_range(1, 3);
                first = cyc + 1; last = first + nb - 1;
                model_exit(sb, nb);
                push(K_FALL, last + 2 + (REL - PRE), sb, m_cnt);
                push(K_APP1, last + 2 + (REL - PRE) + STG, sb, m_cnt);
                pulse(sb, nb);
            end else begin
                push(K_FALL, last + 2 + (REL - PRE), sa, m_cnt);
                if (mode == 0)
                    push(K_APP1, last + 2 + (REL - PRE) + STG, sa, m_cnt);
                pulse(sa, na);
                if (mode == 2) begin
                    // Second exit during the app stagger window.
                    repeat ($urandom_range(21, 27)) @(negedge pld_clk);
                    sb = 5'($urandom_range(1, 31)); nb = $urandom_range(1, 3);
                    first = cyc + 1; last = first + nb - 1;
                    model_exit(sb, nb);
                    push(K_RISE, first + 3, 5'd0, 0);
                    push(K_FALL, last + 2 + (REL - PRE), sb, m_cnt);
                    push(K_APP1, last + 2 + (REL - PRE) + STG, sb, m_cnt);
                    pulse(sb, nb);
                end
            end
            drain(200);
        end

        // ltssm detect and l2 exit together: one exit cycle, both cause bits.
        idle_ltssm = 5'h03;
        @(negedge pld_clk);
        first = cyc + 1; last = first;
        model_exit(5'b01001, 1);
        push(K_RISE, first + 3, 5'd0, 0);
        push(K_FALL, last + 2 + (REL - PRE), 5'b01001, m_cnt);
        push(K_APP1, last + 2 + (REL - PRE) + STG, 5'b01001, m_cnt);
        pulse(5'b01001, 1);
        drain(100);

        // Software request: acts on the full-mask DUT, ignored by the masked one.
        chk("m_busy_pre", m_busy, 0);
        @(negedge pld_clk);
        first = cyc + 1; last = first;
        model_exit(5'b10000, 1);
        push(K_RISE, first + 3, 5'd0, 0);
        push(K_FALL, last + 2 + (REL - PRE), 5'b10000, m_cnt);
        push(K_APP1, last + 2 + (REL - PRE) + STG, 5'b10000, m_cnt);
        pulse(5'b10000, 1);
        repeat (5) @(negedge pld_clk);
        chk("m_srst_sw", m_srst, 0);
        chk("m_app_sw", m_app_rstn, 3);
        chk("m_cause_sw", m_rst_cause, m2_cause);
        chk("m_cnt_sw", m_exit_cnt, m2_cnt);
        drain(100);

        // Asynchronous reset during STAGGER aborts and restarts the full sequence.
        @(negedge pld_clk);
        first = cyc + 1; last = first;
        model_exit(5'b00010, 1);
        push(K_RISE, first + 3, 5'd0, 0);
        push(K_FALL, last + 2 + (REL - PRE), 5'b00010, m_cnt);
        pulse(5'b00010, 1);
        drain(100);
        repeat (5) @(negedge pld_clk);
        sb_on = 1'b0;
        @(posedge pld_clk);
        #3 any_rstn_rr = 1'b0;
        #1;
        chk("arst_srst", srst, 1);
        chk("arst_crst", crst, 1);
        chk("arst_app", app_rstn, 0);
        chk("arst_cause", rst_cause, 0);
        chk("arst_cnt", exit_cnt, 0);
        chk("arst_busy", busy, 1);
        sbq.delete();
        reset_release(2 + REL);
        drain(1200);

        // Fast simulation release.
        sb_on = 1'b0;
        @(negedge pld_clk);
        any_rstn_rr = 1'b0;
        test_sim = 1'b1;
        reset_release(2 + SIMREL);
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
